// File: rtl/lab2_proc_div_pkg.sv
// Shared encodings, FSM state type and sizing constants for the iterative divider.
package lab2_proc_div_pkg;

    localparam int DIV_NBITS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_NBITS);

    localparam logic [1:0] DIV_FN_DIV  = 2'd0;
    localparam logic [1:0] DIV_FN_DIVU = 2'd1;
    localparam logic [1:0] DIV_FN_REM  = 2'd2;
    localparam logic [1:0] DIV_FN_REMU = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/lab2_proc_div_step.sv
// One restoring-division iteration: shift the dividend MSB into the remainder,
// conditionally subtract the divisor and shift the quotient bit into the dividend register.
module lab2_proc_div_step #(
    parameter int NBITS = 32
) (
    input  logic [NBITS:0]   rem_i,
    input  logic [NBITS-1:0] dvd_i,
    input  logic [NBITS-1:0] dvs_i,
    output logic [NBITS:0]   rem_o,
    output logic [NBITS-1:0] dvd_o
);

    logic [NBITS:0] shifted;
    logic [NBITS:0] diff;
    logic           ge;

    always_comb begin
        shifted = {rem_i[NBITS-1:0], dvd_i[NBITS-1]};
        diff    = shifted - {1'b0, dvs_i};
        // Remainder stays below the divisor, so its top bit only matters if it were ever set.
        ge      = rem_i[NBITS] | (shifted >= {1'b0, dvs_i});
        rem_o   = ge ? diff : shifted;
        dvd_o   = {dvd_i[NBITS-2:0], ge};
    end

endmodule

// File: rtl/lab2_proc_iter_div_rem.sv
// Iterative restoring DIV/DIVU/REM/REMU unit with val/rdy request and response.
// Optional early-out for |a| < |b| is enabled by defining LAB2_PROC_DIV_EARLY_OUT_EN.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one quotient bit per cycle, or one pass-through cycle for bypassed ops
// DONE  | result held on resp_msg until the consumer takes it
module lab2_proc_iter_div_rem
    import lab2_proc_div_pkg::*;
#(
    parameter int NBITS = DIV_NBITS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [1:0]       req_fn,
    input  logic [NBITS-1:0] req_a,
    input  logic [NBITS-1:0] req_b,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] resp_msg
);

    localparam int CNT_W = (NBITS == DIV_NBITS) ? DIV_CNT_W : $clog2(NBITS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBITS:0]   rem_q, rem_d;
    logic [NBITS-1:0] dvd_q, dvd_d;
    logic [NBITS-1:0] dvs_q, dvs_d;
    logic             want_rem_q, want_rem_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             byp_q, byp_d;
    logic [NBITS-1:0] byp_msg_q, byp_msg_d;
    logic [NBITS-1:0] resp_msg_q, resp_msg_d;

    logic             signed_op, req_is_rem, a_sign, b_sign, b_zero, early;
    logic [NBITS-1:0] a_mag, b_mag;
    logic [NBITS:0]   step_rem;
    logic [NBITS-1:0] step_dvd, q_fix, r_fix;

    lab2_proc_div_step #(.NBITS(NBITS)) u_step (
        .rem_i (rem_q),
        .dvd_i (dvd_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .dvd_o (step_dvd)
    );

    always_comb begin
        signed_op  = (req_fn == DIV_FN_DIV) || (req_fn == DIV_FN_REM);
        req_is_rem = (req_fn == DIV_FN_REM) || (req_fn == DIV_FN_REMU);
        a_sign     = signed_op & req_a[NBITS-1];
        b_sign     = signed_op & req_b[NBITS-1];
        a_mag      = a_sign ? (-req_a) : req_a;
        b_mag      = b_sign ? (-req_b) : req_b;
        b_zero     = (req_b == '0);
`ifdef LAB2_PROC_DIV_EARLY_OUT_EN
        early      = !b_zero && (a_mag < b_mag);
`else
        early      = 1'b0;
`endif
        q_fix      = neg_q_q ? (-step_dvd) : step_dvd;
        r_fix      = neg_r_q ? (-step_rem[NBITS-1:0]) : step_rem[NBITS-1:0];
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        want_rem_d = want_rem_q;
        neg_q_d    = neg_q_q;
        neg_r_d    = neg_r_q;
        byp_d      = byp_q;
        byp_msg_d  = byp_msg_q;
        resp_msg_d = resp_msg_q;
        case (state_q)
            IDLE: begin
                if (req_val) begin
                    want_rem_d = req_is_rem;
                    neg_q_d    = a_sign ^ b_sign;
                    neg_r_d    = a_sign;
                    rem_d      = '0;
                    dvd_d      = a_mag;
                    dvs_d      = b_mag;
                    cnt_d      = CNT_W'(NBITS - 1);
                    byp_d      = b_zero | early;
                    // Both bypasses return the raw dividend as remainder.
                    byp_msg_d  = req_is_rem ? req_a : (b_zero ? '1 : '0);
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (byp_q) begin
                    resp_msg_d = byp_msg_q;
                    state_d    = DONE;
                end else begin
                    rem_d = step_rem;
                    dvd_d = step_dvd;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        resp_msg_d = want_rem_q ? r_fix : q_fix;
                        state_d    = DONE;
                    end
                end
            end
            DONE: begin
                if (resp_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            want_rem_q <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            byp_q      <= 1'b0;
            byp_msg_q  <= '0;
            resp_msg_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            want_rem_q <= want_rem_d;
            neg_q_q    <= neg_q_d;
            neg_r_q    <= neg_r_d;
            byp_q      <= byp_d;
            byp_msg_q  <= byp_msg_d;
            resp_msg_q <= resp_msg_d;
        end
    end

    // Gated by reset so the request side reads not-ready while reset is held.
    assign req_rdy  = (state_q == IDLE) && reset_n;
    assign resp_val = (state_q == DONE);
    assign resp_msg = resp_msg_q;

endmodule

// File: tb/tb_lab2_proc_iter_div_rem.sv
// Self-checking bench for lab2_proc_iter_div_rem against an arithmetic reference model.
module tb_lab2_proc_iter_div_rem;

    localparam int NB = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          req_val = 1'b0;
    logic          req_rdy;
    logic [1:0]    req_fn = 2'd0;
    logic [NB-1:0] req_a = '0;
    logic [NB-1:0] req_b = '0;
    logic          resp_val;
    logic          resp_rdy = 1'b0;
    logic [NB-1:0] resp_msg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lab2_proc_iter_div_rem #(.NBITS(NB)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .req_fn   (req_fn),
        .req_a    (req_a),
        .req_b    (req_b),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .resp_msg (resp_msg)
    );

    function automatic logic [NB-1:0] model(input logic [1:0] fn, input logic [NB-1:0] a,
                                            input logic [NB-1:0] b);
        int  sa, sb;
        bit  is_signed = (fn == 2'd0) || (fn == 2'd2);
        bit  is_rem    = (fn >= 2'd2);
        if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
        if (!is_signed) return is_rem ? (a % b) : (a / b);
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : a;
        sa = a;
        sb = b;
        return is_rem ? (sa % sb) : (sa / sb);
    endfunction

    function automatic int exp_latency(input logic [1:0] fn, input logic [NB-1:0] a,
                                       input logic [NB-1:0] b);
        longint ma, mb;
        bit is_signed = (fn == 2'd0) || (fn == 2'd2);
        ma = (is_signed && a[NB-1]) ? (64'd4294967296 - longint'(a)) : longint'(a);
        mb = (is_signed && b[NB-1]) ? (64'd4294967296 - longint'(b)) : longint'(b);
        if (b == 0) return 1;
`ifdef LAB2_PROC_DIV_EARLY_OUT_EN
        if (ma < mb) return 1;
`else
        if (ma < mb) return NB;
`endif
        return NB;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue(input logic [1:0] fn, input logic [NB-1:0] a, input logic [NB-1:0] b);
        int n = 0;
        while (!req_rdy && n < 200) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL issue_rdy: req_rdy=%b required 1", req_rdy);
        end
        req_val = 1'b1; req_fn = fn; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic wait_resp(input string name, input logic [NB-1:0] exp, input int exp_lat);
        int lat = 0;
        while (resp_val !== 1'b1 && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required %0d", name, lat, exp_lat);
        end
        checks++;
        if (resp_msg !== exp) begin
            errors++;
            $display("FAIL %s msg: got %h required %h", name, resp_msg, exp);
        end
        checks++;
        if (req_rdy !== 1'b0) begin
            errors++;
            $display("FAIL %s rdy_in_done: req_rdy=%b required 0", name, req_rdy);
        end
    endtask

    task automatic respond(input string name);
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s after_hs: resp_val=%b req_rdy=%b required 0/1", name, resp_val, req_rdy);
        end
    endtask

    task automatic run_op(input string name, input logic [1:0] fn, input logic [NB-1:0] a,
                          input logic [NB-1:0] b);
        issue(fn, a, b);
        wait_resp(name, model(fn, a, b), exp_latency(fn, a, b));
        respond(name);
    endtask

    task automatic test_reset;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_rdy !== 1'b0 || resp_val !== 1'b0 || resp_msg !== '0) begin
            errors++;
            $display("FAIL reset_hold: rdy=%b val=%b msg=%h required 0/0/0", req_rdy, resp_val, resp_msg);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: rdy=%b val=%b required 1/0", req_rdy, resp_val);
        end
    endtask

    task automatic test_directed;
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
        run_op("remu_100_7", 2'd3, 32'd100, 32'd7);
        run_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_5_0",    2'd0, 32'd5, 32'd0);
        run_op("divu_5_0",   2'd1, 32'd5, 32'd0);
        run_op("rem_m5_0",   2'd2, 32'hFFFF_FFFB, 32'd0);
        run_op("div_ovf",    2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",    2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_max_1", 2'd1, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_backpressure;
        issue(2'd1, 32'd1000, 32'd10);
        wait_resp("bp_divu", 32'd100, NB);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_val !== 1'b1 || resp_msg !== 32'd100 || req_rdy !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: val=%b msg=%h rdy=%b required 1/00000064/0",
                         i, resp_val, resp_msg, req_rdy);
            end
        end
        respond("bp_divu");
    endtask

    task automatic test_back_to_back;
        issue(2'd1, 32'd50, 32'd5);
        wait_resp("b2b_first", 32'd10, NB);
        req_val = 1'b1; req_fn = 2'd1; req_a = 32'd77; req_b = 32'd7;
        resp_rdy = 1'b1;
        @(posedge clk); #1;
        resp_rdy = 1'b0;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_overlap: rdy=%b val=%b required 1/0", req_rdy, resp_val);
        end
        @(posedge clk); #1;
        req_val = 1'b0;
        wait_resp("b2b_second", 32'd11, NB);
        respond("b2b_second");
    endtask

    task automatic test_random;
        logic [1:0]    fn;
        logic [NB-1:0] a, b;
        for (int i = 0; i < 30; i++) begin
            fn = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom_range(0, 20); b = $urandom_range(0, 20); end
                1: begin a = $urandom; b = $urandom; end
                2: begin a = $urandom; b = '0; end
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin a = $urandom_range(0, 255); b = $urandom | 32'h0001_0000; end
                default: begin
                    a = $urandom;
                    b = $urandom_range(1, 15);
                    if ($urandom_range(0, 1) == 1) b = -b;
                end
            endcase
            run_op($sformatf("rand%0d", i), fn, a, b);
        end
    endtask

    task automatic test_reset_mid_op;
        issue(2'd1, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (resp_val !== 1'b0 || req_rdy !== 1'b0 || resp_msg !== '0) begin
            errors++;
            $display("FAIL mid_reset: val=%b rdy=%b msg=%h required 0/0/0", resp_val, req_rdy, resp_msg);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_rdy !== 1'b1 || resp_val !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release: rdy=%b val=%b required 1/0", req_rdy, resp_val);
        end
        run_op("post_rst_9_3", 2'd1, 32'd9, 32'd3);
        run_op("post_rst_3_9", 2'd1, 32'd3, 32'd9);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
